bsg_flow_convert_credit: RTL

BSG_FLOW_CONVERT_CREDIT -- requirements
Module: bsg_flow_convert_credit

---
 rtl/bsg_flow_convert_credit.sv | 62 ++++++
 1 files changed

// File: rtl/bsg_flow_convert_credit.sv
// Per-channel ready/valid to valid/credit converter.
// Each channel holds a saturating credit counter with a sticky overflow flag.
module bsg_flow_convert_credit #(
  parameter int channels_p = 32,
  parameter int credits_p  = 4,
  localparam int cnt_width_lp = $clog2(credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [channels_p-1:0]              v_i,
  output logic [channels_p-1:0]              ready_o,
  output logic [channels_p-1:0]              v_o,
  input  logic [channels_p-1:0]              credit_i,
  output logic [channels_p*cnt_width_lp-1:0] credit_cnt_o,
  output logic [channels_p-1:0]              err_o,
  input  logic                               err_clr_i
);

  localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(credits_p);
  localparam logic [cnt_width_lp-1:0] one_lp  = cnt_width_lp'(1);

  logic [channels_p-1:0][cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [channels_p-1:0]                   err_q, err_d;
  logic [channels_p-1:0]                   ovf;

  always_comb begin
    ready_o = '0;
    v_o     = '0;
    ovf     = '0;
    cnt_d   = cnt_q;
    err_d   = err_clr_i ? '0 : err_q;
    for (int c = 0; c < channels_p; c++) begin
      // Ready comes from registered state only; a returning credit
      // at zero count is not bypassed to the upstream.
      ready_o[c] = reset_n_i & (cnt_q[c] != '0);
      v_o[c]     = v_i[c] & ready_o[c];
      unique case ({v_o[c], credit_i[c]})
        2'b10: cnt_d[c] = cnt_q[c] - one_lp;
        2'b01: begin
          if (cnt_q[c] == full_lp) ovf[c] = 1'b1;
          else cnt_d[c] = cnt_q[c] + one_lp;
        end
        default: ;
      endcase
    end
    err_d = err_d | ovf;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= {channels_p{full_lp}};
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credit_cnt_o = cnt_q;
  assign err_o        = err_q;

endmodule
